// File: rtl/ksa_sum_stage.sv
// Final sum stage of a 32-bit Kogge-Stone adder with flags and a
// two-entry skid output buffer.
//
// state | meaning
// EMPTY | no bundle held, out_valid_o = 0
// ONE   | main register holds the head bundle
// FULL  | main holds the head, skid holds the next bundle, in_ready_o = 0
module ksa_sum_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] g_in,
  input  logic [31:0] h_in,
  input  logic        cin_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] sum_o,
  output logic        cout_o,
  output logic        ovf_o,
  output logic        zero_o,
  output logic        neg_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] count_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sum_new;
  logic [35:0] bundle_new;
  logic [35:0] main_q;
  logic [35:0] skid_q;
  logic        in_ready_q;
  logic [15:0] count_q;
  logic        in_fire;
  logic        out_fire;
  logic        load_main_new;
  logic        load_main_skid;
  logic        load_skid;

  // g_in[i-1] is the carry into bit i; cin_i is the carry into bit 0.
  assign sum_new    = h_in ^ {g_in[30:0], cin_i};
  assign bundle_new = {sum_new, g_in[31], g_in[31] ^ g_in[30],
                       (sum_new == 32'd0), sum_new[31]};

  assign in_fire     = in_valid_i & in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_fire    = out_valid_o & out_ready_i;

  assign in_ready_o = in_ready_q;
  assign sum_o      = main_q[35:4];
  assign cout_o     = main_q[3];
  assign ovf_o      = main_q[2];
  assign zero_o     = main_q[1];
  assign neg_o      = main_q[0];
  assign count_o    = count_q;

  // Next-state and register load selection.
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d       = ONE;
          load_main_new = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_new = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next state so it has
  // no combinational dependence on out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Main and skid bundle registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= 36'd0;
      skid_q <= 36'd0;
    end else begin
      if (load_main_new) begin
        main_q <= bundle_new;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bundle_new;
      end
    end
  end

  // Completed output transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 16'd0;
    end else if (out_fire) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: doc/ksa_sum_stage.md
KSA_SUM_STAGE -- requirements
Module: ksa_sum_stage

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 g_in  input  32  group generate G[i:0] from the final prefix stage; carry-in is already folded in at bit 0, so g_in[i] is the carry out of bit i.
REQ-005 h_in  input  32  bitwise half-sum a[i]^b[i] from the pre-processing stage, aligned with g_in.
REQ-006 cin_i  input  1  adder carry-in, aligned with g_in/h_in.
REQ-007 in_valid_i  input  1  g_in/h_in/cin_i carry a valid operand set.
REQ-008 in_ready_o  output  1  the block accepts an input this cycle.
REQ-009 sum_o  output  32  registered sum.
REQ-010 cout_o  output  1  registered carry-out.
REQ-011 ovf_o  output  1  registered signed overflow.
REQ-012 zero_o  output  1  registered flag: sum_o == 0.
REQ-013 neg_o  output  1  registered flag: sum_o[31].
REQ-014 out_valid_o  output  1  the output bundle is valid.
REQ-015 out_ready_i  input  1  the downstream block accepts the output bundle.
REQ-016 count_o  output  16  number of completed output transfers.

Function
REQ-017 Sum: sum[0] = h_in[0]^cin_i; sum[i] = h_in[i]^g_in[i-1] for i = 1..31.
REQ-018 cout = g_in[31]; ovf = g_in[31]^g_in[30]; zero = (sum == 0); neg = sum[31].
REQ-019 Transfers: input fires when in_valid_i && in_ready_o; output fires when out_valid_o && out_ready_i.
REQ-020 Storage: a main output register plus one skid register; each entry holds the 36-bit bundle {sum, cout, ovf, zero, neg}.
REQ-021 States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
REQ-022 in_ready_o = 1 in EMPTY and ONE and 0 in FULL; in_ready_o is a registered signal with no combinational path from out_ready_i.
REQ-023 out_valid_o = 1 in ONE and FULL.
REQ-024 Latency: an input accepted at edge N appears on the outputs after edge N when the block was EMPTY, or when it was ONE and the output fired in the same cycle.
REQ-025 EMPTY, input fires: go to ONE and load main.
REQ-026 ONE, input fires and output fires: stay in ONE and load main with the new bundle.
REQ-027 ONE, input fires without an output fire: go to FULL and load skid.
REQ-028 ONE, output fires without an input fire: go to EMPTY.
REQ-029 FULL, output fires: move skid to main and go to ONE; no input can fire in FULL.
REQ-030 Outputs SHALL hold stable while out_valid_o && !out_ready_i.
REQ-031 Ordering: bundles leave strictly in acceptance order, with none lost and none duplicated.
REQ-032 count_o increments by 1 on each output fire and wraps from 0xFFFF to 0x0000.
REQ-033 in_valid_i with in_ready_o = 0 SHALL be ignored without corrupting state.

Reset
REQ-034 On rst_i = 1 at an edge: state EMPTY, out_valid_o = 0, in_ready_o = 1, count_o = 0, and sum_o/cout_o/ovf_o/zero_o/neg_o = 0.
REQ-035 A reset asserted mid-operation SHALL discard both entries, and no output fire is counted in that cycle.
REQ-036 The first input SHALL be accepted on the first edge after rst_i deasserts.

Verification
REQ-037 Operands a = 0x7FFFFFFF, b = 0x00000001, cin = 0, out_ready_i = 1 -> next cycle: sum_o = 0x80000000, cout_o = 0, ovf_o = 1, neg_o = 1, zero_o = 0.
REQ-038 Operands a = 0xFFFFFFFF, b = 0x00000000, cin = 1 -> sum_o = 0, cout_o = 1, ovf_o = 0, zero_o = 1.
REQ-039 Backpressure: out_ready_i = 0 while 3 inputs are offered back-to-back -> 2 accepted, in_ready_o = 0 from the cycle after the 2nd; raising out_ready_i drains both in order, and the 3rd is then accepted.
REQ-040 Streaming: in_valid_i = 1 and out_ready_i = 1 for 100 cycles -> 100 transfers, one per cycle, count_o = 100, and every sum equals a + b + cin against a reference model.
REQ-041 Reset while FULL -> next cycle: out_valid_o = 0, in_ready_o = 1, count_o = 0.
REQ-042 Preload count_o with 0xFFFF transfers, then one more transfer -> count_o = 0x0000.
